fifo_uart_tx: RTL

- UART transmitter that drains the team's synchronous FIFO from its read side and serializes each word onto a single line, LSB first.
- Pulls one word per frame using the FIFO's read-enable / empty / registered-data-out interface, which has 1-cycle read latency.
- Sits directly downstream of the FIFO; its output txd goes to the pad or board-level UART.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_baud_counter.sv | 15 +
 rtl/fifo_uart_tx.sv | 90 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and frame/parity helpers for the FIFO-fed UART transmitter
package uart_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} tx_state_t;
  localparam int MAX_DATAWIDTH = 64;
  function automatic int frame_bits(input int data_width, input int parity_en, input int stop_bits);
    return 1 + data_width + parity_en + stop_bits;
  endfunction
  function automatic int frame_cycles(input int data_width, input int parity_en, input int stop_bits, input int clks_per_bit);
    return frame_bits(data_width, parity_en, stop_bits) * clks_per_bit;
  endfunction
  function automatic logic parity_of(input logic [MAX_DATAWIDTH-1:0] d, input logic odd);
    return ^d ^ odd;
  endfunction
endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: divides clk into bit periods, bit_tick marks the last cycle of each
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic bit_tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt;
  assign bit_tick = cnt == W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk)
    cnt <= (!reset_n || clear || bit_tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pulls one word per frame from a 1-cycle-latency FIFO and serializes it LSB first
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATAWIDTH    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_enable,
  input  logic                 fifo_empty,
  input  logic [DATAWIDTH-1:0] fifo_rdata,
  output logic                 fifo_rd_en,
  output logic                 txd,
  output logic                 busy,
  output logic                 frame_done
);
  localparam int BW = DATAWIDTH > 1 ? $clog2(DATAWIDTH) : 1;
  localparam int SL = STOP_BITS * CLKS_PER_BIT;
  localparam int SW = $clog2(SL);
  tx_state_t            state;
  logic [DATAWIDTH-1:0] shreg, shnext;
  logic [BW-1:0]        bit_cnt;
  logic [SW-1:0]        stop_cnt;
  logic                 par, bit_tick;
  assign shnext     = shreg >> 1;
  assign fifo_rd_en = reset_n && state == IDLE && tx_enable && !fifo_empty;
  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (state == IDLE || state == FETCH),
    .bit_tick (bit_tick)
  );
  always_ff @(posedge clk)
    if (!reset_n) begin
      state      <= IDLE;
      txd        <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= '0;
      par        <= 1'b0;
    end else
      case (state)
        IDLE: if (fifo_rd_en) begin
          state <= FETCH;
          busy  <= 1'b1;
        end
        FETCH: begin
          shreg <= fifo_rdata;
          par   <= parity_of(MAX_DATAWIDTH'(fifo_rdata), 1'(PARITY_ODD));
          txd   <= 1'b0;
          state <= START;
        end
        START: if (bit_tick) begin
          state   <= DATA;
          txd     <= shreg[0];
          bit_cnt <= '0;
        end
        DATA: if (bit_tick) begin
          shreg <= shnext;
          if (bit_cnt == BW'(DATAWIDTH - 1)) begin
            state    <= PARITY_EN != 0 ? PARITY : STOP;
            txd      <= PARITY_EN != 0 ? par : 1'b1;
            stop_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            txd     <= shnext[0];
          end
        end
        PARITY: if (bit_tick) begin
          state    <= STOP;
          txd      <= 1'b1;
          stop_cnt <= '0;
        end
        STOP: begin
          stop_cnt   <= stop_cnt + 1'b1;
          frame_done <= stop_cnt == SW'(SL - 2);
          if (stop_cnt == SW'(SL - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
endmodule
